// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced core with req/ack instruction and data memories.
// Define CPU_MUL_EN to make opcode A a MUL; otherwise it is reported as illegal.
module multicycle_cpu #(
   parameter int DATA_W  = 8,
   parameter int REG_CNT = 4,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic              illegal_op,
   output logic              halted
);
   localparam int RW = $clog2(REG_CNT);
`ifdef CPU_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, sext_a, pc_inc;
   logic [15:0] ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d, sext_d, alu;
   logic [DATA_W-1:0] regs_q [REG_CNT];
   logic [DATA_W-1:0] regs_d [REG_CNT];
   logic [3:0] op;
   logic [RW-1:0] rd, rs1, rs2;
   logic is_alu, is_mem, legal;
   assign op     = ir_q[15:12];
   assign rd     = RW'(ir_q[11:8]);
   assign rs1    = RW'(ir_q[7:4]);
   assign rs2    = RW'(ir_q[3:0]);
   assign sext_d = DATA_W'($signed(ir_q[3:0]));
   assign sext_a = ADDR_W'($signed(ir_q[3:0]));
   assign pc_inc = pc_q + ADDR_W'(1);
   assign is_alu = (op >= 4'h1 && op <= 4'h5) || (MUL_EN && op == 4'hA);
   assign is_mem = op == 4'h6 || op == 4'h7;
   assign legal  = op <= 4'h9 || op == 4'hF || (MUL_EN && op == 4'hA);
   assign alu    = op == 4'h1 ? a_q + c_q :
                   op == 4'h2 ? a_q - c_q :
                   op == 4'h3 ? a_q & c_q :
                   op == 4'h4 ? a_q | c_q :
                   (MUL_EN && op == 4'hA) ? a_q * c_q : a_q + sext_d;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = b_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         addr_q  <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         regs_q  <= regs_d;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      regs_d  = regs_q;
      case (state_q)
         FETCH: if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = DECODE;
         end
         DECODE: begin
            a_d     = regs_q[rs1];
            b_d     = regs_q[rd];
            c_d     = regs_q[rs2];
            state_d = EXEC;
         end
         EXEC: if (is_alu) begin
            res_d   = alu;
            state_d = WB;
         end else if (is_mem) begin
            addr_d  = ADDR_W'(a_q) + sext_a;
            state_d = MEM;
         end else if (op == 4'hF) begin
            state_d = HALT;
         end else begin
            // NOP and illegal opcodes fall through to a plain increment
            pc_d    = op == 4'h8 ? (a_q == b_q ? pc_inc + sext_a : pc_inc) :
                      op == 4'h9 ? ir_q[ADDR_W-1:0] : pc_inc;
            state_d = FETCH;
         end
         MEM: if (dmem_ack) begin
            res_d   = dmem_rdata;
            pc_d    = op == 4'h7 ? pc_inc : pc_q;
            state_d = op == 4'h7 ? FETCH : WB;
         end
         WB: begin
            if (rd != '0) regs_d[rd] = res_q;
            pc_d    = pc_inc;
            state_d = FETCH;
         end
         default: state_d = state_q;
      endcase
   end
   always_comb begin
      imem_req   = !reset && state_q == FETCH;
      dmem_req   = !reset && state_q == MEM;
      dmem_we    = dmem_req && op == 4'h7;
      retire     = !reset && ((state_q == EXEC && !is_alu && !is_mem) ||
                              (state_q == MEM && dmem_ack && op == 4'h7) || state_q == WB);
      illegal_op = !reset && state_q == EXEC && !legal;
      halted     = !reset && state_q == HALT;
   end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed program vectors plus handshake and reset corner cases.
module tb_multicycle_cpu;
   localparam int DW = 8;
   localparam int AW = 8;
   logic clk = 1'b0, reset = 1'b1;
   logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, illegal_op, halted;
   logic [AW-1:0] imem_addr, dmem_addr, pc;
   logic [15:0] imem_rdata;
   logic [DW-1:0] dmem_wdata, dmem_rdata;
   logic [15:0] imem [256];
   logic [DW-1:0] dmem [256];
   int dwait = 0, dcnt = 0, tests = 0, fails = 0;
   logic dack_block = 1'b0, dack_force = 1'b0, iack_block = 1'b0;
   logic pk_en = 1'b0;
   logic [7:0] pk_a = '0;
   logic [DW-1:0] pk_d = '0;
   always #5 clk = ~clk;
   multicycle_cpu dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .pc(pc), .retire(retire), .illegal_op(illegal_op), .halted(halted)
   );
   assign imem_ack   = imem_req & ~iack_block;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ack   = dack_force | (dmem_req & ~dack_block & (dcnt >= dwait));
   assign dmem_rdata = dmem[dmem_addr];
   always @(posedge clk) begin
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      if (pk_en) dmem[pk_a] <= pk_d;
      else if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end
   typedef struct {
      string name;
      logic [0:7][15:0] prog;
      int ra;
      logic [7:0] ea;
      int rb;
      logic [7:0] eb;
      logic [7:0] epc;
      int eret;
      int eill;
      int ecyc;
   } vec_t;
   vec_t v [8];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
      end
   endtask
   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask
   task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
      pk_a = a;
      pk_d = d;
      pk_en = 1'b1;
      @(negedge clk);
      pk_en = 1'b0;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic run(input int budget, output int cyc, output int ret, output int ill);
      logic pv, pw;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      do_reset();
      cyc = 0; ret = 0; ill = 0;
      pv = 1'b0; pw = 1'b0; pa = '0; pd = '0;
      while (!halted && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (retire) ret++;
         if (illegal_op) ill++;
         if (dmem_req && pv) chk("dmem_hold", {dmem_addr, dmem_we, dmem_wdata}, {pa, pw, pd});
         pv = dmem_req; pa = dmem_addr; pw = dmem_we; pd = dmem_wdata;
      end
      if (!halted) chk("halt_timeout", halted, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int cyc, ret, ill;
      v[0] = '{"plan", {16'h5103, 16'h520E, 16'h1312, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0},
               3, 8'h01, 2, 8'hFE, 8'h03, 4, 0, 15};
      v[1] = '{"sub", {16'h5105, 16'h5207, 16'h2312, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0},
               3, 8'hFE, 1, 8'h05, 8'h03, 4, 0, 15};
      v[2] = '{"andor", {16'h510C, 16'h5206, 16'h3312, 16'h4112, 16'hF000, 16'h0, 16'h0, 16'h0},
               3, 8'h04, 1, 8'hFE, 8'h04, 5, 0, 19};
      v[3] = '{"r0", {16'h5107, 16'h5017, 16'h1200, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0},
               2, 8'h00, 0, 8'h00, 8'h03, 4, 0, 15};
      v[4] = '{"illegal", {16'h5101, 16'h0000, 16'h0000, 16'h0000, 16'hC123, 16'h5211, 16'hF000, 16'h0},
               2, 8'h02, 1, 8'h01, 8'h06, 7, 1, 23};
`ifdef CPU_MUL_EN
      v[5] = '{"opA", {16'h5107, 16'h1111, 16'h5111, 16'h5202, 16'h1212, 16'hA312, 16'hF000, 16'h0},
               3, 8'hFF, 2, 8'h11, 8'h06, 7, 0, 27};
`else
      v[5] = '{"opA", {16'h5107, 16'h1111, 16'h5111, 16'h5202, 16'h1212, 16'hA312, 16'hF000, 16'h0},
               3, 8'h00, 2, 8'h11, 8'h06, 7, 1, 26};
`endif
      v[6] = '{"beq_t", {16'h5103, 16'h5203, 16'h8211, 16'h5305, 16'hF000, 16'h0, 16'h0, 16'h0},
               3, 8'h00, 2, 8'h03, 8'h04, 4, 0, 14};
      v[7] = '{"beq_nt", {16'h5103, 16'h5203, 16'h8011, 16'h5305, 16'hF000, 16'h0, 16'h0, 16'h0},
               3, 8'h05, 1, 8'h03, 8'h04, 5, 0, 18};
      clear_imem();
      repeat (2) @(negedge clk);
      chk("rst.pc", pc, 0);
      chk("rst.req", {imem_req, dmem_req, dmem_we}, 0);
      chk("rst.dbus", {dmem_addr, dmem_wdata}, 0);
      chk("rst.pulses", {retire, illegal_op, halted}, 0);
      for (int r = 0; r < 4; r++) chk("rst.reg", dut.regs_q[r], 0);
      for (int i = 0; i < 8; i++) begin
         clear_imem();
         for (int k = 0; k < 8; k++) imem[k] = v[i].prog[k];
         run(100, cyc, ret, ill);
         chk({v[i].name, ".cycles"}, cyc, v[i].ecyc);
         chk({v[i].name, ".ra"}, dut.regs_q[v[i].ra], v[i].ea);
         chk({v[i].name, ".rb"}, dut.regs_q[v[i].rb], v[i].eb);
         chk({v[i].name, ".retire"}, ret, v[i].eret);
         chk({v[i].name, ".illegal"}, ill, v[i].eill);
         for (int k = 0; k < 3; k++) begin
            chk({v[i].name, ".idle"}, {imem_req, dmem_req, halted}, 3'b001);
            chk({v[i].name, ".pc"}, pc, v[i].epc);
            @(negedge clk);
         end
      end
      // wait-stated data memory: LW, SW, LW back
      clear_imem();
      imem[0] = 16'h6103; imem[1] = 16'h7105; imem[2] = 16'h6205; imem[3] = 16'hF000;
      poke(8'd3, 8'hA5);
      poke(8'd5, 8'h00);
      dwait = 3;
      run(200, cyc, ret, ill);
      dwait = 0;
      chk("mem.cycles", cyc, 26);
      chk("mem.r1", dut.regs_q[1], 8'hA5);
      chk("mem.r2", dut.regs_q[2], 8'hA5);
      chk("mem.store", dmem[5], 8'hA5);
      chk("mem.retire", ret, 4);
      // BEQ at pc 10, taken backwards then not taken
      clear_imem();
      imem[0] = 16'h900A; imem[10] = 16'h800E; imem[9] = 16'hF000;
      run(100, cyc, ret, ill);
      chk("beq10_t.pc", pc, 8'h09);
      chk("beq10_t.cycles", cyc, 9);
      chk("beq10_t.retire", ret, 3);
      clear_imem();
      imem[0] = 16'h5101; imem[1] = 16'h900A; imem[10] = 16'h801E; imem[11] = 16'hF000;
      run(100, cyc, ret, ill);
      chk("beq10_nt.pc", pc, 8'h0B);
      chk("beq10_nt.cycles", cyc, 13);
      // J to 0xFFF truncates to 0xFF, then increment wraps
      clear_imem();
      imem[0] = 16'h9FFF; imem[255] = 16'h5104;
      do_reset();
      cyc = 0;
      while (pc == 8'h00 && cyc < 10) begin @(negedge clk); cyc++; end
      chk("jwrap.pc", pc, 8'hFF);
      chk("jwrap.cycles", cyc, 3);
      while (pc == 8'hFF && cyc < 20) begin @(negedge clk); cyc++; end
      chk("wrap.pc", pc, 8'h00);
      chk("wrap.cycles", cyc, 7);
      chk("wrap.r1", dut.regs_q[1], 8'h04);
      // reset while a load waits for its ack, then a stale ack
      clear_imem();
      imem[0] = 16'h5101; imem[1] = 16'h6205; imem[2] = 16'hF000;
      poke(8'd5, 8'h33);
      poke(8'd0, 8'h77);
      dack_block = 1'b1;
      do_reset();
      cyc = 0;
      while (!dmem_req && cyc < 20) begin @(negedge clk); cyc++; end
      chk("mid.req", dmem_req, 1);
      chk("mid.cycles", cyc, 7);
      chk("mid.addr", dmem_addr, 8'h05);
      chk("mid.r1", dut.regs_q[1], 8'h01);
      repeat (2) @(negedge clk);
      chk("mid.hold", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 8'h05});
      reset = 1'b1;
      iack_block = 1'b1;
      @(negedge clk);
      chk("mid.rst_req", dmem_req, 0);
      chk("mid.rst_pc", pc, 0);
      chk("mid.rst_addr", dmem_addr, 0);
      chk("mid.rst_r1", dut.regs_q[1], 0);
      reset = 1'b0;
      dack_block = 1'b0;
      dack_force = 1'b1;
      repeat (3) @(negedge clk);
      chk("stale.r1", dut.regs_q[1], 0);
      chk("stale.r2", dut.regs_q[2], 0);
      chk("stale.pc", pc, 0);
      chk("stale.req", {imem_req, dmem_req}, 2'b10);
      dack_force = 1'b0;
      iack_block = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised successor to the single-cycle 8-bit CPU top.
- Multi-cycle core: one FSM sequences fetch, decode, execute, memory and writeback over shared datapath registers.
- Instruction and data memories are external, behind req/ack handshakes, so wait-states are tolerated.
- Generalised in data width, register count and PC width; adds BEQ, a HALT state, illegal-opcode detection and a retire pulse.

Parameters:
- DATA_W, 8, datapath and register width (>=4).
- REG_CNT, 4, number of GPRs (power of 2, 2..16); r0 reads as zero, writes to it are ignored.
- ADDR_W, 8, PC and data-address width (<=12).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  16  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- pc  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal_op  out  1  one-cycle pulse on undefined opcode.
- halted  out  1  core stopped.

Behaviour:
- Instruction fields: op[15:12], rd[11:8], rs1[7:4], imm4[3:0] (also rs2); J target = instr[11:0].
- Register indices use the low log2(REG_CNT) bits of each field.
- sext(imm4) is sign-extended to DATA_W for ALU use and to ADDR_W for address use.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2.
  - 2 SUB rd=rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 ADDI rd=rs1+sext(imm4).
  - 6 LW rd=mem[rs1+sext(imm4)].
  - 7 SW mem[rs1+sext(imm4)]=rd.
  - 8 BEQ: if rs1==rd then pc=pc+1+sext(imm4).
  - 9 J pc=target[ADDR_W-1:0].
  - F HALT.
  - All others: illegal.
- Arithmetic is modulo 2^DATA_W; no flags.
- Address = low ADDR_W bits of (rs1+sext), modulo 2^ADDR_W.
- PC increments modulo 2^ADDR_W.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On ack: latch instruction register, go to DECODE.
  - Ack may arrive in the first req cycle.
- DECODE: read rs1/rd/rs2 into operand registers, go to EXEC.
- EXEC:
  - ALU ops/ADDI: compute result, go to WB.
  - LW/SW: compute address, go to MEM.
  - NOP/BEQ/J/illegal: update pc, pulse retire, go to FETCH. illegal_op also pulses; illegal behaves as NOP.
  - HALT: pulse retire, go to HALT.
- MEM:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack.
  - LW: on ack latch rdata, go to WB.
  - SW: on ack, pc=pc+1, pulse retire, go to FETCH.
- WB: write rd (unless r0), pc=pc+1, pulse retire, go to FETCH.
- Zero-wait CPI:
  - ALU: 4.
  - LW: 5.
  - SW: 4.
  - NOP/BEQ/J: 3.
- HALT:
  - halted=1; no further requests; only reset exits.
- Reset, including mid-handshake:
  - State=FETCH, pc=0, all GPRs=0, instruction register=0.
  - imem_req=dmem_req=dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - retire=illegal_op=halted=0.
  - An in-flight request is abandoned; a late ack arriving outside the matching state is ignored.
- Reads of rd for SW/BEQ use the value from before the current instruction (no forwarding needed: only one instruction is in flight).

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: opcode A = MUL, rd = low DATA_W bits of rs1*rs2, 4-cycle path like ADD.
- Undefined: opcode A is illegal (illegal_op pulse, NOP behaviour).

Test Plan:
- Reset then program {ADDI r1,r0,3; ADDI r2,r0,-2; ADD r3,r1,r2; HALT}, zero-wait memories -> r3=1, 4 retire pulses, halted=1 at cycle 15 after reset release, pc=3.
- SW r1→[r0+5] with r1=0xA5, then LW r2,[r0+5]; dmem_ack delayed 3 cycles -> request signals stable until ack, r2=0xA5.
- BEQ taken (r1==r2) with imm4=-2 at pc=10 -> next fetch at pc=9; BEQ not taken -> pc=11.
- Opcode 0xC at pc=4 -> one illegal_op pulse, no register change, next fetch at pc=5; with CPU_MUL_EN, opcode A with r1=0x0F, r2=0x11 -> rd=0xFF. Without it, opcode A behaves as illegal.
- Assert reset during MEM with dmem_ack held 0 -> next cycle dmem_req=0, pc=0, all registers 0; a stale ack afterwards causes no write.
- ADDI r0,r1,7 then ADD r2,r0,r0 -> r2=0 (r0 hardwired); J 0xFFF with ADDR_W=8 -> pc=0xFF, then pc increment wraps to 0x00.
